chien_search_ctrl: RTL and testbench
====================================

Name: chien_search_ctrl

Overview:
Sequencer for the RS(204,188) Chien-search datapath, which evaluates the error-locator polynomial at one alpha exponent per cycle and flags roots. It accepts sigma coefficients and the locator degree from the Berlekamp-Massey stage over a valid/ready handshake. It loads the datapath, sweeps exponents 1..255, and collects root exponents as error locations. It checks the root count against the degree and presents locations, count and a fail flag to the Forney/correction stage.

Parameters:
T, 8, maximum correctable errors (number of sigma coefficients and location slots)
SYM_W, 8, GF(2^8) symbol / exponent width
N, 255, last exponent swept (first is 1)
DP_LAT, 1, cycles from dp_exp issue to the matching dp_root flag

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-low reset
sigma_valid  in  1  upstream coefficients/degree valid
sigma_ready  out  1  controller can accept a new locator
sigma_flat  in  T*SYM_W  Sigma1 at [7:0] .. SigmaT at top, log-domain as used by the datapath
sigma_deg  in  4  locator degree from BM (0..15)
dp_load  out  1  one-cycle pulse: datapath latches dp_sigma and resets its evaluation
dp_sigma  out  T*SYM_W  registered copy of sigma_flat
dp_exp  out  SYM_W  exponent being evaluated this cycle
dp_root  in  1  datapath: polynomial evaluated to zero for exponent issued DP_LAT cycles earlier
loc_valid  out  1  results valid, held until accepted
loc_ready  in  1  downstream accepts results
loc_flat  out  T*SYM_W  root exponents, slot 0 = first found (lowest exponent); unused slots 0
loc_count  out  4  number of roots captured (0..T)
decode_fail  out  1  uncorrectable block; valid with loc_valid
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, Reset=0): state IDLE. Outputs: sigma_ready=1, dp_load=0, dp_sigma=0, dp_exp=0, loc_valid=0, loc_flat=0, loc_count=0, decode_fail=0, busy=0. Internal counters are cleared. Assertion mid-search aborts with no output.
- IDLE: sigma_ready=1. On sigma_valid&sigma_ready, register sigma_flat and sigma_deg, and clear loc_flat, loc_count and the overflow flag. Next state:
  - sigma_deg > T: CHECK with overflow=1.
  - sigma_deg == 0: CHECK directly. No search runs and no dp_load is issued.
  - otherwise: LOAD.
- LOAD (1 cycle): dp_load=1, dp_exp=1 → SEARCH.
- SEARCH: dp_exp increments by 1 per cycle from 1 to N. It does not wrap and holds at N. A delay line of DP_LAT tags each issued exponent. When dp_root is high and its tagged exponent is valid:
  - if loc_count<T: write the exponent to slot loc_count and increment loc_count.
  - otherwise: set overflow and leave loc_count saturated at T.
  dp_root is ignored when no tagged exponent is in flight. SEARCH lasts N+DP_LAT cycles after LOAD, then → CHECK.
- CHECK (1 cycle): decode_fail = overflow | (loc_count != sigma_deg). → OUTPUT.
- OUTPUT: loc_valid=1. loc_flat, loc_count and decode_fail are stable until the handshake. On loc_ready: loc_valid=0 next cycle, → IDLE. sigma_ready=0 here, so a back-to-back block is accepted one cycle after the handshake.
- sigma_ready=0 in every state except IDLE. sigma_valid is ignored and must be held by upstream.
- Latency, sigma handshake to loc_valid: 1 + 1 + N + DP_LAT + 1 cycles = 259 with the defaults (degree 1..T).

Decomposition:
- Shared package rs_dec_pkg: T, SYM_W, N, state enum {IDLE, LOAD, SEARCH, CHECK, OUTPUT}, deg_t (4-bit). Same package as the other RS decoder blocks.
- One sub-module, root_capture: the T-slot location register file with write pointer, saturation and overflow flag. The FSM, exponent counter and DP_LAT tag delay line stay in chien_search_ctrl.

Test Plan:
- Degree 2, datapath model roots at exponents 17 and 200 → loc_flat slot0=17, slot1=200, loc_count=2, decode_fail=0; loc_valid rises 259 cycles after the sigma handshake.
- Degree 3, only 2 roots (40, 41) → loc_count=2, decode_fail=1.
- Degree 8, model asserts dp_root on 9 exponents (1, 2, ..., 9) → loc_count=8 (slots 1..8), slot for 9 not written, decode_fail=1. Also check that roots at exponents 1 and 255 are both captured in a separate degree-2 run.
- sigma_deg=0 → loc_valid two cycles after the handshake, loc_count=0, decode_fail=0, no dp_load pulse. Separately, sigma_deg=12 → decode_fail=1 without a search.
- Hold loc_ready=0 for 20 cycles while sigma_valid is pending → outputs stable, sigma_ready=0. Release → next block accepted one cycle after the handshake.
- Assert Reset=0 asynchronously mid-SEARCH at dp_exp=100 → all outputs return to reset values immediately. A new block after release completes correctly with no stale locations.

Source files
------------

// File: rtl/rs_dec_pkg.sv
// Shared RS(204,188) decoder definitions: code parameters, locator degree type, sequencer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rs_dec_pkg;

    // Maximum correctable errors: number of sigma coefficients and location slots.
    localparam int T     = 8;
    // GF(2^8) symbol / exponent width.
    localparam int SYM_W = 8;
    // Last alpha exponent evaluated by the Chien sweep (the first is 1).
    localparam int N     = 255;

    // Locator degree as reported by Berlekamp-Massey (0..15).
    typedef logic [3:0] deg_t;

    // Sequencer states. Plain constants keep the encoding fixed for older blocks
    // that decode the state bits directly.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_SEARCH = 3'd2;
    localparam state_t ST_CHECK  = 3'd3;
    localparam state_t ST_OUTPUT = 3'd4;

    // A degree above T cannot be corrected whatever the search finds.
    function automatic logic deg_too_big(input deg_t deg);
        return deg > deg_t'(T);
    endfunction

endpackage

// File: rtl/root_capture.sv
// T-slot root-location register file with write pointer, saturating count and overflow flag.
// Latency: a write is visible on loc_flat/loc_count the cycle after wr_vld.
// Backpressure: none; writes beyond T slots are dropped and raise overflow instead.
//
// Ports:
//   Clk, Reset          clock, asynchronous active-low reset
//   clear, set_ovf      empty all slots; overflow takes set_ovf on the same edge
//   wr_vld, wr_exp      store one root exponent in the next free slot
//   loc_flat            slot 0 at [SYM_W-1:0]; unused slots read 0
//   loc_count           slots filled (0..T)
//   overflow            more roots seen than slots, or forced by set_ovf
module root_capture
    import rs_dec_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               clear,
    input  logic               set_ovf,
    input  logic               wr_vld,
    input  logic [SYM_W-1:0]   wr_exp,
    output logic [T*SYM_W-1:0] loc_flat,
    output deg_t               loc_count,
    output logic               overflow
);

    logic [SYM_W-1:0] slot [T];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < T; i++) begin
                slot[i] <= '0;
            end
            loc_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < T; i++) begin
                slot[i] <= '0;
            end
            loc_count <= '0;
            overflow  <= set_ovf;
        end else if (wr_vld) begin
            if (loc_count < deg_t'(T)) begin
                // loc_count doubles as the write pointer
                for (int i = 0; i < T; i++) begin
                    if (loc_count == deg_t'(i)) begin
                        slot[i] <= wr_exp;
                    end
                end
                loc_count <= loc_count + deg_t'(1);
            end else begin
                // Count stays saturated at T; the extra root only marks the block bad
                overflow <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < T; g++) begin : g_flat
        assign loc_flat[g*SYM_W +: SYM_W] = slot[g];
    end

endmodule

// File: rtl/chien_search_ctrl.sv
// Chien-search sequencer: loads the locator into the datapath, sweeps exponents 1..N, collects roots.
// Latency: sigma handshake cycle to loc_valid is 1+1+N+DP_LAT+1 cycles (2 when no search runs).
// Backpressure: sigma_ready only in IDLE; results held on loc_valid until loc_ready.
//
// Ports:
//   Clk, Reset                       clock, asynchronous active-low reset
//   sigma_valid/ready, sigma_flat,   locator coefficients and degree from Berlekamp-Massey
//   sigma_deg
//   dp_load, dp_sigma, dp_exp        datapath control: load pulse, coefficients, exponent issued
//   dp_root                          datapath flag for the exponent issued DP_LAT cycles earlier
//   loc_valid/ready, loc_flat,       results to Forney/correction
//   loc_count, decode_fail
//   busy                             high in every state except IDLE
module chien_search_ctrl
    import rs_dec_pkg::*;
#(
    parameter int DP_LAT = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               sigma_valid,
    output logic               sigma_ready,
    input  logic [T*SYM_W-1:0] sigma_flat,
    input  deg_t               sigma_deg,
    output logic               dp_load,
    output logic [T*SYM_W-1:0] dp_sigma,
    output logic [SYM_W-1:0]   dp_exp,
    input  logic               dp_root,
    output logic               loc_valid,
    input  logic               loc_ready,
    output logic [T*SYM_W-1:0] loc_flat,
    output deg_t               loc_count,
    output logic               decode_fail,
    output logic               busy
);

    localparam int               CNT_W       = $clog2(N + DP_LAT + 1);
    // Exponents are issued during the first N search cycles only
    localparam logic [CNT_W-1:0] ISSUE_END   = CNT_W'(N);
    // The last DP_LAT cycles only drain results still in the datapath
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(N + DP_LAT - 1);
    localparam logic [SYM_W-1:0] EXP_LAST    = SYM_W'(N);

    state_t           state;
    deg_t             deg_q;
    logic [CNT_W-1:0] srch_cnt;
    logic             tag_vld [DP_LAT];
    logic [SYM_W-1:0] tag_exp [DP_LAT];

    logic accept;
    logic issue_vld;
    logic cap_vld;
    logic overflow;

    assign accept    = (state == ST_IDLE) && sigma_valid;
    assign issue_vld = (state == ST_SEARCH) && (srch_cnt < ISSUE_END);
    // A root flag with no tagged exponent in flight (load cycle, drain tail,
    // idle) belongs to no valid evaluation and is dropped
    assign cap_vld   = dp_root && tag_vld[DP_LAT-1];

    assign sigma_ready = (state == ST_IDLE);
    assign dp_load     = (state == ST_LOAD);
    assign loc_valid   = (state == ST_OUTPUT);
    assign busy        = (state != ST_IDLE);

    // Sequencer, exponent counter and registered datapath coefficients
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            deg_q       <= '0;
            srch_cnt    <= '0;
            dp_exp      <= '0;
            dp_sigma    <= '0;
            decode_fail <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dp_sigma    <= sigma_flat;
                        deg_q       <= sigma_deg;
                        decode_fail <= 1'b0;
                        // Degree 0 or above T: nothing worth searching for
                        if (deg_too_big(sigma_deg) || (sigma_deg == '0)) begin
                            state <= ST_CHECK;
                        end else begin
                            state  <= ST_LOAD;
                            dp_exp <= SYM_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    // dp_exp stays at 1 so the first search cycle issues exponent 1
                    // against the freshly loaded coefficients
                    srch_cnt <= '0;
                    state    <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    srch_cnt <= srch_cnt + CNT_W'(1);
                    if (dp_exp != EXP_LAST) begin
                        dp_exp <= dp_exp + SYM_W'(1);
                    end
                    if (srch_cnt == SEARCH_LAST) begin
                        dp_exp <= '0;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // The final root lands on the edge into CHECK, so the count here is complete
                    decode_fail <= overflow | (loc_count != deg_q);
                    state       <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (loc_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag delay line: pairs each dp_root with the exponent that produced it
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DP_LAT; i++) begin
                tag_vld[i] <= 1'b0;
                tag_exp[i] <= '0;
            end
        end else begin
            tag_vld[0] <= issue_vld;
            tag_exp[0] <= dp_exp;
            for (int i = 1; i < DP_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_exp[i] <= tag_exp[i-1];
            end
        end
    end

    root_capture u_root_capture (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (accept),
        .set_ovf   (deg_too_big(sigma_deg)),
        .wr_vld    (cap_vld),
        .wr_exp    (tag_exp[DP_LAT-1]),
        .loc_flat  (loc_flat),
        .loc_count (loc_count),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_chien_search_ctrl.sv
// Self-checking bench for chien_search_ctrl with a behavioural datapath and result model.
// Latency: n/a.
// Backpressure: exercises loc_ready hold-off with a pending sigma_valid.
module tb_chien_search_ctrl;
    import rs_dec_pkg::*;

    logic               Clk;
    logic               Reset;
    logic               sigma_valid;
    logic               sigma_ready;
    logic [T*SYM_W-1:0] sigma_flat;
    deg_t               sigma_deg;
    logic               dp_load;
    logic [T*SYM_W-1:0] dp_sigma;
    logic [SYM_W-1:0]   dp_exp;
    logic               dp_root;
    logic               loc_valid;
    logic               loc_ready;
    logic [T*SYM_W-1:0] loc_flat;
    deg_t               loc_count;
    logic               decode_fail;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    // Roots the datapath model reports for the current block
    bit                 root_set [256];
    bit                 dp_armed;
    bit                 ev_vld;
    logic [SYM_W-1:0]   ev_exp;
    logic [T*SYM_W-1:0] cur_sigma;

    chien_search_ctrl #(.DP_LAT(1)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .sigma_valid (sigma_valid),
        .sigma_ready (sigma_ready),
        .sigma_flat  (sigma_flat),
        .sigma_deg   (sigma_deg),
        .dp_load     (dp_load),
        .dp_sigma    (dp_sigma),
        .dp_exp      (dp_exp),
        .dp_root     (dp_root),
        .loc_valid   (loc_valid),
        .loc_ready   (loc_ready),
        .loc_flat    (loc_flat),
        .loc_count   (loc_count),
        .decode_fail (decode_fail),
        .busy        (busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural datapath: one cycle after an exponent is presented (and after
    // a load has reset it) it reports whether that exponent is a root. Outside
    // an evaluation it drives random noise that the controller must ignore.
    always @(negedge Clk) begin
        if (ev_vld && ev_exp != '0) dp_root = root_set[ev_exp];
        else                        dp_root = 1'($urandom_range(0, 1));
        if (!Reset) begin
            dp_armed = 1'b0;
            ev_vld   = 1'b0;
        end else if (dp_load) begin
            dp_armed = 1'b1;
            ev_vld   = 1'b0;
        end else begin
            ev_vld = dp_armed;
        end
        ev_exp = dp_exp;
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic clear_roots();
        foreach (root_set[i]) root_set[i] = 1'b0;
    endtask

    // Expected results from the rules: roots in ascending exponent order fill
    // the slots, extras beyond T are counted but not stored.
    task automatic model(input int deg, output logic [63:0] flat, output int cnt, output bit fail);
        int n;
        n    = 0;
        flat = '0;
        cnt  = 0;
        if (deg == 0 || deg > T) begin
            fail = (deg > T);
            return;
        end
        for (int e = 1; e <= N; e++) begin
            if (root_set[e]) begin
                if (n < T) flat[n*SYM_W +: SYM_W] = e[7:0];
                n++;
            end
        end
        cnt  = (n < T) ? n : T;
        fail = (n > T) || (n != deg);
    endtask

    // Present a block and wait for its handshake; returns one cycle later.
    task automatic start_block(input int deg, input logic [63:0] flat);
        sigma_flat  = flat;
        sigma_deg   = deg[3:0];
        sigma_valid = 1'b1;
        for (int i = 0; i < 50 && !sigma_ready; i++) @(negedge Clk);
        chk("accept", sigma_ready, 1);
        cur_sigma = flat;
        @(negedge Clk);
        sigma_valid = 1'b0;
    endtask

    // Wait for results, check them, optionally hold loc_ready low for a while
    // (with the next block already pending), then take the results.
    task automatic finish_block(input int deg, input int hold, input bit prearm,
                                input int nxt_deg, input logic [63:0] nxt_flat);
        logic [63:0] e_flat;
        int          e_cnt;
        bit          e_fail;
        int          lat;
        int          loads;
        bit          seen;
        int          e_lat;
        model(deg, e_flat, e_cnt, e_fail);
        e_lat = (deg == 0 || deg > T) ? 2 : (1 + 1 + N + 1 + 1);
        lat   = 1;
        loads = 0;
        seen  = 1'b0;
        chk("busy", busy, 1);
        chk("dp_sigma", dp_sigma, cur_sigma);
        for (int i = 0; i < 400; i++) begin
            if (dp_load) loads++;
            if (loc_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge Clk);
            lat++;
        end
        chk("loc_valid_seen", seen, 1);
        chk("latency", lat, e_lat);
        chk("dp_load_pulses", loads, (deg >= 1 && deg <= T) ? 1 : 0);
        chk("loc_flat", loc_flat, e_flat);
        chk("loc_count", loc_count, e_cnt);
        chk("decode_fail", decode_fail, e_fail);
        chk("ready_in_output", sigma_ready, 0);
        if (prearm) begin
            sigma_flat  = nxt_flat;
            sigma_deg   = nxt_deg[3:0];
            sigma_valid = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            chk("hold_out", {loc_valid, sigma_ready, loc_flat, loc_count, decode_fail},
                {1'b1, 1'b0, e_flat, e_cnt[3:0], e_fail});
        end
        loc_ready = 1'b1;
        @(negedge Clk);
        loc_ready = 1'b0;
        chk("after_take", {loc_valid, sigma_ready, busy}, 3'b010);
    endtask

    initial begin
        int          deg;
        int          nr;
        logic [63:0] nxt;

        Reset       = 1'b0;
        sigma_valid = 1'b0;
        sigma_flat  = '0;
        sigma_deg   = '0;
        loc_ready   = 1'b0;
        clear_roots();
        #3;
        chk("reset_ctl", {sigma_ready, busy, loc_valid, dp_load, decode_fail}, 5'b10000);
        chk("reset_dp", {dp_exp, dp_sigma}, 0);
        chk("reset_loc", {loc_flat, loc_count}, 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        // Two roots, matching degree
        clear_roots(); root_set[17] = 1; root_set[200] = 1;
        start_block(2, rnd64()); finish_block(2, 0, 0, 0, '0);

        // Fewer roots than the degree
        clear_roots(); root_set[40] = 1; root_set[41] = 1;
        start_block(3, rnd64()); finish_block(3, 0, 0, 0, '0);

        // Nine roots for eight slots
        clear_roots();
        for (int e = 1; e <= 9; e++) root_set[e] = 1;
        start_block(8, rnd64()); finish_block(8, 0, 0, 0, '0);

        // Both sweep end points
        clear_roots(); root_set[1] = 1; root_set[255] = 1;
        start_block(2, rnd64()); finish_block(2, 0, 0, 0, '0);

        // Degree 0 and degree above T skip the search
        clear_roots(); root_set[9] = 1;
        start_block(0, rnd64()); finish_block(0, 0, 0, 0, '0);
        start_block(12, rnd64()); finish_block(12, 0, 0, 0, '0);

        // Results held off for 20 cycles with the next block already waiting
        clear_roots();
        root_set[5] = 1; root_set[66] = 1; root_set[99] = 1; root_set[150] = 1; root_set[254] = 1;
        nxt = rnd64();
        start_block(5, rnd64()); finish_block(5, 20, 1, 1, nxt);
        clear_roots(); root_set[128] = 1;
        start_block(1, nxt); finish_block(1, 0, 0, 0, '0);

        // Asynchronous reset in the middle of the sweep
        clear_roots(); root_set[30] = 1; root_set[60] = 1;
        start_block(4, rnd64());
        for (int i = 0; i < 300 && dp_exp != 8'd100; i++) @(negedge Clk);
        chk("reach_exp100", dp_exp, 100);
        #2 Reset = 1'b0;
        #1;
        chk("abort_ctl", {sigma_ready, busy, loc_valid, dp_load, decode_fail}, 5'b10000);
        chk("abort_dp", {dp_exp, dp_sigma}, 0);
        chk("abort_loc", {loc_flat, loc_count}, 0);
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        clear_roots(); root_set[3] = 1; root_set[250] = 1;
        start_block(2, rnd64()); finish_block(2, 0, 0, 0, '0);

        // Random blocks
        for (int b = 0; b < 8; b++) begin
            clear_roots();
            deg = $urandom_range(0, 10);
            nr  = ($urandom_range(0, 1) == 1) ? deg : $urandom_range(0, 10);
            for (int r = 0; r < nr; r++) root_set[$urandom_range(1, N)] = 1;
            start_block(deg, rnd64());
            finish_block(deg, $urandom_range(0, 3), 0, 0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
